instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the P5 instruction decode: accepts symbolic instruction commands (kind + fields),
//  encodes them into 32-bit MIPS words, buffers them in a FIFO, and streams them as sequential
//  word writes into instruction memory from BASE_ADDR. Used by program loaders and benches.
// PARAMETERS
//  DEPTH      8             FIFO entries (power of 2, >=2)
//  BASE_ADDR  32'h0000_3000 first IM write address; restart/reset returns here
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  restart      in   1   sync: flush FIFO, im_addr<=BASE_ADDR, word_count<=0
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_kind     in   4   0 ADD,1 SUB,2 JR,3 NOP,4 ORI,5 LW,6 SW,7 BEQ,8 LUI,9 JAL; 10-15 illegal
//  cmd_rs/rt/rd in   5   register fields
//  cmd_imm      in   16  immediate / branch offset
//  cmd_target   in   26  JAL target field
//  im_we        out  1   word valid toward IM
//  im_ready     in   1   IM accepts; transfer when im_we&&im_ready
//  im_addr      out  32  write address (word-aligned)
//  im_wdata     out  32  encoded word (FIFO head)
//  word_count   out  16  words transferred since reset/restart, saturates at 16'hFFFF
//  illegal      out  1   one-cycle pulse: illegal kind accepted and dropped
// BEHAVIOUR
//  Encoding (fields fixed, unused bits 0):
//   ADD {6'h00,rs,rt,rd,5'b0,6'h20}  SUB same, funct 6'h22  JR {6'h00,rs,15'b0,6'h08}
//   NOP 32'h0  ORI {6'h0D,rs,rt,imm}  LW {6'h23,rs,rt,imm}  SW {6'h2B,rs,rt,imm}
//   BEQ {6'h04,rs,rt,imm}  LUI {6'h0F,5'b0,rt,imm}  JAL {6'h03,target}
//  Accept: encode combinationally, write FIFO tail on accept edge. Latency: accepted in cycle N
//   -> earliest im_we with that word in cycle N+1 (no bypass).
//  cmd_ready = free entries >= needed (1; 2 for branch/jump when DELAY_SLOT_NOP_EN); combinational
//   from occupancy only, never from cmd_valid.
//  Output: im_we = !empty; im_wdata = head. On transfer: pop, im_addr+=4, word_count+=1 (sat).
//   im_addr wraps 32'hFFFF_FFFC -> 0. Holding im_we with im_ready=0 keeps addr/data stable.
//  Simultaneous push+pop: occupancy unchanged, both take effect; push when full impossible.
//  Illegal kind: handshake completes, nothing enqueued, illegal=1 next cycle for one cycle.
//  reset/restart (reset dominates; same effect): empty FIFO, im_we=0, im_addr=BASE_ADDR,
//   word_count=0, illegal=0, cmd_ready=1 next cycle. Mid-stream restart discards queued words;
//   a command offered in the restart cycle is not accepted (cmd_ready forced 0 that cycle).
//  Reset values: cmd_ready 1 after reset deasserts, im_we 0, im_wdata 32'h0 (head don't-care
//   masked to 0 when empty), im_addr BASE_ADDR, word_count 0, illegal 0.
// CONFIGURATION
//  DELAY_SLOT_NOP_EN defined: each accepted BEQ/JR/JAL enqueues its word then 32'h0 in the
//   same cycle (2 entries); cmd_ready requires >=2 free. Undefined: every kind enqueues exactly
//   one word; no implicit NOPs.
// TESTING
//  1 ADD rs1 rt2 rd3 -> im_we cycle N+1, addr 0x3000, data 0x00221820; word_count 1.
//  2 ORI rs0 rt1 imm 0x1234, LUI rt1 imm 0xFFFF, LW rs0 rt4 imm 8 back-to-back, im_ready=1
//    -> 0x34011234@0x3000, 0x3C01FFFF@0x3004, 0x8C040008@0x3008, one per cycle.
//  3 im_ready=0, push DEPTH cmds -> cmd_ready drops after 8th; raise im_ready -> 8 words in
//    order, addrs 0x3000..0x301C, cmd_ready returns after first pop.
//  4 kind 12 -> accepted, illegal pulse one cycle, no im_we, word_count unchanged.
//  5 BEQ rs1 rt2 imm 3, JAL target 0x0000C03 -> 0x10220003, 0x0C000C03; with
//    DELAY_SLOT_NOP_EN: 0x10220003,0x0,0x0C000C03,0x0 at 0x3000..0x300C.
//  6 3 words queued, pulse restart -> im_we 0 next cycle, im_addr 0x3000, word_count 0;
//    next ADD lands at 0x3000.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Command and instruction-memory write bus for instr_encoder.
// The slave modport is the encoder's view; master is the loader/bench side.
interface instr_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_kind;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        im_we;
  logic        im_ready;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic [15:0] word_count;
  logic        illegal;

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, im_ready,
    input  cmd_ready, im_we, im_addr, im_wdata, word_count, illegal
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, im_ready,
    output cmd_ready, im_we, im_addr, im_wdata, word_count, illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic commands into MIPS words, queues them, and streams them into IM from BASE_ADDR.
// Optional DELAY_SLOT_NOP_EN: BEQ/JR/JAL also enqueue a trailing NOP word.
module instr_encoder #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input logic clk,
  input logic reset,
  input logic restart,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
`ifdef DELAY_SLOT_NOP_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic [PW:0]   freeSlots;
  logic [PW:0]   pushCount;
  logic [31:0]   imAddr;
  logic [15:0]   wordCount;
  logic          illegalPulse;
  logic [31:0]   encWord;
  logic          kindLegal;
  logic          isBranch;
  logic          accept;
  logic          push;
  logic          pushTwo;
  logic          pop;

  always_comb begin
    encWord   = 32'h0;
    kindLegal = 1'b1;
    isBranch  = 1'b0;
    case (bus.cmd_kind)
      4'd0: encWord = {6'h00, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'b0, 6'h20};
      4'd1: encWord = {6'h00, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'b0, 6'h22};
      4'd2: begin
        encWord  = {6'h00, bus.cmd_rs, 15'b0, 6'h08};
        isBranch = 1'b1;
      end
      4'd3: encWord = 32'h0;
      4'd4: encWord = {6'h0D, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      4'd5: encWord = {6'h23, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      4'd6: encWord = {6'h2B, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
      4'd7: begin
        encWord  = {6'h04, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
        isBranch = 1'b1;
      end
      4'd8: encWord = {6'h0F, 5'b0, bus.cmd_rt, bus.cmd_imm};
      4'd9: begin
        encWord  = {6'h03, bus.cmd_target};
        isBranch = 1'b1;
      end
      default: kindLegal = 1'b0;
    endcase
  end

  // Ready reserves the worst-case entry count so it never depends on the offered command.
  assign freeSlots     = (PW+1)'(DEPTH) - count;
  assign bus.cmd_ready = !reset && !restart && (freeSlots >= (PW+1)'(NEED));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign push          = accept && kindLegal;
`ifdef DELAY_SLOT_NOP_EN
  assign pushTwo       = push && isBranch;
`else
  assign pushTwo       = 1'b0;
`endif
  assign pushCount     = (PW+1)'(push) + (PW+1)'(pushTwo);
  assign bus.im_we     = (count != '0);
  assign pop           = bus.im_we && bus.im_ready;
  assign bus.im_wdata  = bus.im_we ? mem[rdPtr] : 32'h0;
  assign bus.im_addr   = imAddr;
  assign bus.word_count = wordCount;
  assign bus.illegal   = illegalPulse;

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= encWord;
    if (pushTwo) mem[wrPtr + 1'b1] <= 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      imAddr       <= BASE_ADDR;
      wordCount    <= 16'h0;
      illegalPulse <= 1'b0;
    end else begin
      wrPtr        <= wrPtr + pushCount[PW-1:0];
      count        <= count + pushCount - (PW+1)'(pop);
      illegalPulse <= accept && !kindLegal;
      if (pop) begin
        rdPtr  <= rdPtr + 1'b1;
        imAddr <= imAddr + 32'd4;
        if (wordCount != 16'hFFFF) wordCount <= wordCount + 16'd1;
      end
    end
  end
endmodule
